// File: rtl/tl_ul_port_buffer.sv
// TileLink-UL port buffer: one registered A (request) queue and one registered
// D (response) queue for a single client port, plus a cap on the number of
// A beats issued downstream that have not yet seen a D beat.
// Both queues are plain circular buffers: no flow-through, no pipe mode.
module tl_ul_port_buffer #(
  parameter int A_DEPTH      = 2,
  parameter int D_DEPTH      = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_in_valid,
  output logic        a_in_ready,
  input  logic [2:0]  a_in_opcode,
  input  logic [2:0]  a_in_param,
  input  logic [3:0]  a_in_size,
  input  logic [1:0]  a_in_source,
  input  logic [31:0] a_in_address,
  input  logic [3:0]  a_in_mask,
  input  logic [31:0] a_in_data,
  input  logic        a_in_corrupt,
  output logic        a_out_valid,
  input  logic        a_out_ready,
  output logic [2:0]  a_out_opcode,
  output logic [2:0]  a_out_param,
  output logic [3:0]  a_out_size,
  output logic [1:0]  a_out_source,
  output logic [31:0] a_out_address,
  output logic [3:0]  a_out_mask,
  output logic [31:0] a_out_data,
  output logic        a_out_corrupt,
  input  logic        d_in_valid,
  output logic        d_in_ready,
  input  logic [2:0]  d_in_opcode,
  input  logic [1:0]  d_in_param,
  input  logic [3:0]  d_in_size,
  input  logic [1:0]  d_in_source,
  input  logic        d_in_denied,
  input  logic [31:0] d_in_data,
  input  logic        d_in_corrupt,
  output logic        d_out_valid,
  input  logic        d_out_ready,
  output logic [2:0]  d_out_opcode,
  output logic [1:0]  d_out_param,
  output logic [3:0]  d_out_size,
  output logic [1:0]  d_out_source,
  output logic        d_out_denied,
  output logic [31:0] d_out_data,
  output logic        d_out_corrupt,
  output logic [3:0]  inflight,
  output logic        err_underflow
);

  localparam int A_W  = 81;
  localparam int D_W  = 45;
  localparam int A_PW = $clog2(A_DEPTH);
  localparam int D_PW = $clog2(D_DEPTH);
  localparam logic [3:0] MAX_INF = 4'(MAX_INFLIGHT);

  logic [A_W-1:0]  a_mem [A_DEPTH];
  logic [A_PW-1:0] a_enq_ptr;
  logic [A_PW-1:0] a_deq_ptr;
  logic            a_maybe_full;
  logic            a_empty;
  logic            a_full;
  logic            a_enq;
  logic            a_deq;

  logic [D_W-1:0]  d_mem [D_DEPTH];
  logic [D_PW-1:0] d_enq_ptr;
  logic [D_PW-1:0] d_deq_ptr;
  logic            d_maybe_full;
  logic            d_empty;
  logic            d_full;
  logic            d_enq;
  logic            d_deq;

  logic            cap_ok;

  assign a_empty = (a_enq_ptr == a_deq_ptr) && !a_maybe_full;
  assign a_full  = (a_enq_ptr == a_deq_ptr) && a_maybe_full;
  assign d_empty = (d_enq_ptr == d_deq_ptr) && !d_maybe_full;
  assign d_full  = (d_enq_ptr == d_deq_ptr) && d_maybe_full;

  // Readiness depends only on stored state, so a full queue refuses a beat
  // even if it is being drained in the same cycle.
  assign cap_ok      = inflight < MAX_INF;
  assign a_in_ready  = !a_full;
  assign a_out_valid = !a_empty && cap_ok;
  assign d_in_ready  = !d_full;
  assign d_out_valid = !d_empty;

  assign a_enq = a_in_valid && a_in_ready;
  assign a_deq = a_out_valid && a_out_ready;
  assign d_enq = d_in_valid && d_in_ready;
  assign d_deq = d_out_valid && d_out_ready;

  // Output fields always reflect the head entry, valid or not.
  assign {a_out_opcode, a_out_param, a_out_size, a_out_source,
          a_out_address, a_out_mask, a_out_data, a_out_corrupt} = a_mem[a_deq_ptr];
  assign {d_out_opcode, d_out_param, d_out_size, d_out_source,
          d_out_denied, d_out_data, d_out_corrupt} = d_mem[d_deq_ptr];

  // A queue: storage, pointers and the full/empty disambiguation flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_enq_ptr    <= '0;
      a_deq_ptr    <= '0;
      a_maybe_full <= 1'b0;
      for (int i = 0; i < A_DEPTH; i++) a_mem[i] <= '0;
    end else begin
      if (a_enq) begin
        a_mem[a_enq_ptr] <= {a_in_opcode, a_in_param, a_in_size, a_in_source,
                             a_in_address, a_in_mask, a_in_data, a_in_corrupt};
        a_enq_ptr <= a_enq_ptr + 1'b1;
      end
      if (a_deq) a_deq_ptr <= a_deq_ptr + 1'b1;
      if (a_enq != a_deq) a_maybe_full <= a_enq;
    end
  end

  // D queue: same structure as the A queue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_enq_ptr    <= '0;
      d_deq_ptr    <= '0;
      d_maybe_full <= 1'b0;
      for (int i = 0; i < D_DEPTH; i++) d_mem[i] <= '0;
    end else begin
      if (d_enq) begin
        d_mem[d_enq_ptr] <= {d_in_opcode, d_in_param, d_in_size, d_in_source,
                             d_in_denied, d_in_data, d_in_corrupt};
        d_enq_ptr <= d_enq_ptr + 1'b1;
      end
      if (d_deq) d_deq_ptr <= d_deq_ptr + 1'b1;
      if (d_enq != d_deq) d_maybe_full <= d_enq;
    end
  end

  // Outstanding-request count; a response with nothing outstanding is
  // flagged (sticky) and the count is held at zero instead of wrapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight      <= 4'd0;
      err_underflow <= 1'b0;
    end else if (a_deq && !d_enq) begin
      inflight <= inflight + 4'd1;
    end else if (d_enq && !a_deq) begin
      if (inflight == 4'd0) err_underflow <= 1'b1;
      else                  inflight      <= inflight - 4'd1;
    end
  end

endmodule

// File: tb/tb_tl_ul_port_buffer.sv
// Bench for tl_ul_port_buffer: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_tl_ul_port_buffer;

  localparam int A_DEPTH = 2;
  localparam int D_DEPTH = 2;
  localparam int MAX_INF = 4;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [3:0]  size;
    logic [1:0]  source;
    logic [31:0] address;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corrupt;
  } a_beat_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [3:0]  size;
    logic [1:0]  source;
    logic        denied;
    logic [31:0] data;
    logic        corrupt;
  } d_beat_t;

  typedef struct {
    logic        av;
    logic [2:0]  aop;
    logic [1:0]  asrc;
    logic [31:0] aaddr;
    logic        aor;
    logic        dv;
    logic [2:0]  dop;
    logic [31:0] ddata;
    logic        dor;
    logic        e_air;
    logic        e_aov;
    logic [1:0]  e_asrc;
    logic [31:0] e_aaddr;
    logic        e_dov;
    logic [31:0] e_ddata;
    logic [3:0]  e_inf;
    logic        e_err;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic        a_in_valid, a_in_ready;
  logic [2:0]  a_in_opcode, a_in_param;
  logic [3:0]  a_in_size;
  logic [1:0]  a_in_source;
  logic [31:0] a_in_address;
  logic [3:0]  a_in_mask;
  logic [31:0] a_in_data;
  logic        a_in_corrupt;
  logic        a_out_valid, a_out_ready;
  logic [2:0]  a_out_opcode, a_out_param;
  logic [3:0]  a_out_size;
  logic [1:0]  a_out_source;
  logic [31:0] a_out_address;
  logic [3:0]  a_out_mask;
  logic [31:0] a_out_data;
  logic        a_out_corrupt;
  logic        d_in_valid, d_in_ready;
  logic [2:0]  d_in_opcode;
  logic [1:0]  d_in_param;
  logic [3:0]  d_in_size;
  logic [1:0]  d_in_source;
  logic        d_in_denied;
  logic [31:0] d_in_data;
  logic        d_in_corrupt;
  logic        d_out_valid, d_out_ready;
  logic [2:0]  d_out_opcode;
  logic [1:0]  d_out_param;
  logic [3:0]  d_out_size;
  logic [1:0]  d_out_source;
  logic        d_out_denied;
  logic [31:0] d_out_data;
  logic        d_out_corrupt;
  logic [3:0]  inflight;
  logic        err_underflow;

  int checks = 0;
  int errors = 0;
  vec_t vecs[15];

  always #5 clock = ~clock;

  tl_ul_port_buffer #(.A_DEPTH(A_DEPTH), .D_DEPTH(D_DEPTH), .MAX_INFLIGHT(MAX_INF)) dut (
    .clock(clock), .reset(reset),
    .a_in_valid(a_in_valid), .a_in_ready(a_in_ready),
    .a_in_opcode(a_in_opcode), .a_in_param(a_in_param), .a_in_size(a_in_size),
    .a_in_source(a_in_source), .a_in_address(a_in_address), .a_in_mask(a_in_mask),
    .a_in_data(a_in_data), .a_in_corrupt(a_in_corrupt),
    .a_out_valid(a_out_valid), .a_out_ready(a_out_ready),
    .a_out_opcode(a_out_opcode), .a_out_param(a_out_param), .a_out_size(a_out_size),
    .a_out_source(a_out_source), .a_out_address(a_out_address), .a_out_mask(a_out_mask),
    .a_out_data(a_out_data), .a_out_corrupt(a_out_corrupt),
    .d_in_valid(d_in_valid), .d_in_ready(d_in_ready),
    .d_in_opcode(d_in_opcode), .d_in_param(d_in_param), .d_in_size(d_in_size),
    .d_in_source(d_in_source), .d_in_denied(d_in_denied), .d_in_data(d_in_data),
    .d_in_corrupt(d_in_corrupt),
    .d_out_valid(d_out_valid), .d_out_ready(d_out_ready),
    .d_out_opcode(d_out_opcode), .d_out_param(d_out_param), .d_out_size(d_out_size),
    .d_out_source(d_out_source), .d_out_denied(d_out_denied), .d_out_data(d_out_data),
    .d_out_corrupt(d_out_corrupt),
    .inflight(inflight), .err_underflow(err_underflow)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    a_in_valid = 0; a_out_ready = 0; d_in_valid = 0; d_out_ready = 0;
    a_in_opcode = 0; a_in_param = 0; a_in_size = 4'd2; a_in_source = 0;
    a_in_address = 0; a_in_mask = 4'hF; a_in_data = 0; a_in_corrupt = 0;
    d_in_opcode = 0; d_in_param = 0; d_in_size = 4'd2; d_in_source = 0;
    d_in_denied = 0; d_in_data = 0; d_in_corrupt = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1;
    @(posedge clock);
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Randomized run against a queue-level model of the port.
  task automatic random_run(input int cycles);
    a_beat_t aq[$];
    d_beat_t dq[$];
    int      m_inf = 0;
    bit      m_err = 0;
    a_beat_t na;
    d_beat_t nd;
    bit      a_enq, a_deq, d_enq, d_deq, exp_aov;
    for (int c = 0; c < cycles; c++) begin
      exp_aov = (aq.size() > 0) && (m_inf < MAX_INF);
      chk("rnd a_in_ready", a_in_ready, aq.size() < A_DEPTH);
      chk("rnd a_out_valid", a_out_valid, exp_aov);
      if (aq.size() > 0)
        chk("rnd a_out fields", {a_out_opcode, a_out_param, a_out_size, a_out_source,
            a_out_address, a_out_mask, a_out_data, a_out_corrupt}, aq[0]);
      chk("rnd d_in_ready", d_in_ready, dq.size() < D_DEPTH);
      chk("rnd d_out_valid", d_out_valid, dq.size() > 0);
      if (dq.size() > 0)
        chk("rnd d_out fields", {d_out_opcode, d_out_param, d_out_size, d_out_source,
            d_out_denied, d_out_data, d_out_corrupt}, dq[0]);
      chk("rnd inflight", inflight, 128'(m_inf));
      chk("rnd err_underflow", err_underflow, m_err);

      na = {$urandom, $urandom, $urandom};
      nd = {$urandom, $urandom};
      a_in_valid  = ($urandom_range(0, 9) < 6);
      a_out_ready = ($urandom_range(0, 9) < 6);
      d_in_valid  = ($urandom_range(0, 9) < 4);
      d_out_ready = ($urandom_range(0, 9) < 7);
      {a_in_opcode, a_in_param, a_in_size, a_in_source,
       a_in_address, a_in_mask, a_in_data, a_in_corrupt} = na;
      {d_in_opcode, d_in_param, d_in_size, d_in_source,
       d_in_denied, d_in_data, d_in_corrupt} = nd;

      a_enq = a_in_valid && (aq.size() < A_DEPTH);
      a_deq = exp_aov && a_out_ready;
      d_enq = d_in_valid && (dq.size() < D_DEPTH);
      d_deq = (dq.size() > 0) && d_out_ready;
      step();
      if (a_deq) void'(aq.pop_front());
      if (a_enq) aq.push_back(na);
      if (d_deq) void'(dq.pop_front());
      if (d_enq) dq.push_back(nd);
      if (a_deq && !d_enq) m_inf++;
      else if (d_enq && !a_deq) begin
        if (m_inf == 0) m_err = 1;
        else m_inf--;
      end
    end
  endtask

  initial begin
    // av aop asrc aaddr aor | dv dop ddata dor | air aov asrc aaddr dov ddata inf err
    vecs[0]  = '{1, 3'd4, 2'd1, 32'h8000_0010, 0, 0, 3'd0, 32'h0,         1, 1, 1, 2'd1, 32'h8000_0010, 0, 32'h0,         4'd0, 0};
    vecs[1]  = '{0, 3'd0, 2'd0, 32'h0,         1, 0, 3'd0, 32'h0,         1, 1, 0, 2'd0, 32'h0,         0, 32'h0,         4'd1, 0};
    vecs[2]  = '{0, 3'd0, 2'd1, 32'h0,         0, 1, 3'd1, 32'hDEAD_BEEF, 0, 1, 0, 2'd0, 32'h0,         1, 32'hDEAD_BEEF, 4'd0, 0};
    vecs[3]  = '{0, 3'd0, 2'd0, 32'h0,         0, 0, 3'd0, 32'h0,         1, 1, 0, 2'd0, 32'h0,         0, 32'h0,         4'd0, 0};
    vecs[4]  = '{1, 3'd4, 2'd0, 32'h1000,      0, 0, 3'd0, 32'h0,         1, 1, 1, 2'd0, 32'h1000,      0, 32'h0,         4'd0, 0};
    vecs[5]  = '{1, 3'd4, 2'd1, 32'h1004,      0, 0, 3'd0, 32'h0,         1, 0, 1, 2'd0, 32'h1000,      0, 32'h0,         4'd0, 0};
    vecs[6]  = '{1, 3'd4, 2'd2, 32'h1008,      0, 0, 3'd0, 32'h0,         1, 0, 1, 2'd0, 32'h1000,      0, 32'h0,         4'd0, 0};
    vecs[7]  = '{1, 3'd4, 2'd2, 32'h1008,      1, 0, 3'd0, 32'h0,         1, 1, 1, 2'd1, 32'h1004,      0, 32'h0,         4'd1, 0};
    vecs[8]  = '{1, 3'd4, 2'd2, 32'h1008,      1, 0, 3'd0, 32'h0,         1, 1, 1, 2'd2, 32'h1008,      0, 32'h0,         4'd2, 0};
    vecs[9]  = '{0, 3'd0, 2'd0, 32'h0,         0, 0, 3'd0, 32'h0,         1, 1, 1, 2'd2, 32'h1008,      0, 32'h0,         4'd2, 0};
    vecs[10] = '{0, 3'd0, 2'd0, 32'h0,         1, 1, 3'd1, 32'h1111_1111, 0, 1, 0, 2'd0, 32'h0,         1, 32'h1111_1111, 4'd2, 0};
    vecs[11] = '{0, 3'd0, 2'd0, 32'h0,         0, 0, 3'd0, 32'h0,         1, 1, 0, 2'd0, 32'h0,         0, 32'h0,         4'd2, 0};
    vecs[12] = '{0, 3'd0, 2'd0, 32'h0,         0, 1, 3'd1, 32'h2222_2222, 1, 1, 0, 2'd0, 32'h0,         1, 32'h2222_2222, 4'd1, 0};
    vecs[13] = '{0, 3'd0, 2'd0, 32'h0,         0, 1, 3'd1, 32'h3333_3333, 1, 1, 0, 2'd0, 32'h0,         1, 32'h3333_3333, 4'd0, 0};
    vecs[14] = '{0, 3'd0, 2'd0, 32'h0,         0, 0, 3'd0, 32'h0,         1, 1, 0, 2'd0, 32'h0,         0, 32'h0,         4'd0, 0};

    do_reset();
    chk("reset a_in_ready", a_in_ready, 1);
    chk("reset d_in_ready", d_in_ready, 1);
    chk("reset a_out_valid", a_out_valid, 0);
    chk("reset d_out_valid", d_out_valid, 0);
    chk("reset inflight", inflight, 0);
    chk("reset err_underflow", err_underflow, 0);
    chk("reset a_out_address", a_out_address, 0);
    chk("reset d_out_data", d_out_data, 0);

    // Directed vector table: single request, backpressure, simultaneous fire.
    for (int i = 0; i < 15; i++) begin
      a_in_valid = vecs[i].av; a_in_opcode = vecs[i].aop; a_in_source = vecs[i].asrc;
      a_in_address = vecs[i].aaddr; a_out_ready = vecs[i].aor;
      d_in_valid = vecs[i].dv; d_in_opcode = vecs[i].dop; d_in_data = vecs[i].ddata;
      d_in_source = vecs[i].asrc; d_out_ready = vecs[i].dor;
      step();
      chk($sformatf("vec%0d a_in_ready", i), a_in_ready, vecs[i].e_air);
      chk($sformatf("vec%0d a_out_valid", i), a_out_valid, vecs[i].e_aov);
      if (vecs[i].e_aov) begin
        chk($sformatf("vec%0d a_out_source", i), a_out_source, vecs[i].e_asrc);
        chk($sformatf("vec%0d a_out_address", i), a_out_address, vecs[i].e_aaddr);
      end
      chk($sformatf("vec%0d d_out_valid", i), d_out_valid, vecs[i].e_dov);
      if (vecs[i].e_dov)
        chk($sformatf("vec%0d d_out_data", i), d_out_data, vecs[i].e_ddata);
      chk($sformatf("vec%0d inflight", i), inflight, vecs[i].e_inf);
      chk($sformatf("vec%0d err_underflow", i), err_underflow, vecs[i].e_err);
    end

    // Cap: five requests with no responses; the fifth waits for a D beat.
    do_reset();
    a_out_ready = 1; d_out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1; a_in_source = 2'(i); a_in_address = 32'h2000 + 32'(i) * 4;
      step();
    end
    a_in_valid = 0;
    chk("cap inflight", inflight, 4);
    chk("cap a_out_valid", a_out_valid, 0);
    chk("cap a_out_address", a_out_address, 32'h2010);
    step();
    chk("cap hold a_out_valid", a_out_valid, 0);
    chk("cap hold inflight", inflight, 4);
    d_in_valid = 1; d_in_opcode = 3'd0;
    step();
    d_in_valid = 0;
    chk("cap release inflight", inflight, 3);
    chk("cap release a_out_valid", a_out_valid, 1);
    chk("cap release a_out_address", a_out_address, 32'h2010);
    step();
    chk("cap final inflight", inflight, 4);
    chk("cap final a_out_valid", a_out_valid, 0);

    // Underflow: response with nothing outstanding.
    do_reset();
    d_in_valid = 1; d_in_opcode = 3'd1; d_in_data = 32'hCAFE_F00D;
    step();
    d_in_valid = 0;
    chk("uflow err", err_underflow, 1);
    chk("uflow inflight", inflight, 0);
    chk("uflow d_out_valid", d_out_valid, 1);
    chk("uflow d_out_data", d_out_data, 32'hCAFE_F00D);
    d_out_ready = 1;
    step();
    chk("uflow drained", d_out_valid, 0);
    repeat (3) step();
    chk("uflow sticky", err_underflow, 1);

    // Reset mid-operation: 2 A beats and 1 D beat queued, inflight 3.
    d_out_ready = 0; a_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1; a_in_source = 2'(i); a_in_address = 32'h3000 + 32'(i);
      step();
    end
    a_in_valid = 0;
    step();
    a_out_ready = 0; a_in_valid = 1;
    repeat (2) step();
    a_in_valid = 0; d_in_valid = 1; d_in_data = 32'h5555_AAAA;
    step();
    d_in_valid = 0;
    chk("midrst pre inflight", inflight, 3);
    chk("midrst pre a_in_ready", a_in_ready, 0);
    chk("midrst pre d_out_valid", d_out_valid, 1);
    chk("midrst pre err", err_underflow, 1);
    reset = 0;
    #1;
    chk("midrst a_out_valid", a_out_valid, 0);
    chk("midrst d_out_valid", d_out_valid, 0);
    chk("midrst a_in_ready", a_in_ready, 1);
    chk("midrst d_in_ready", d_in_ready, 1);
    chk("midrst inflight", inflight, 0);
    chk("midrst err", err_underflow, 0);
    chk("midrst a_out_address", a_out_address, 0);
    @(negedge clock) reset = 1;
    a_out_ready = 1; d_out_ready = 1;
    repeat (2) step();
    chk("midrst after a_out_valid", a_out_valid, 0);
    chk("midrst after d_out_valid", d_out_valid, 0);

    // Randomized traffic against the reference model.
    do_reset();
    random_run(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
